vga_capture: RTL and testbench

Passive VGA sink that sits on the HS/VS/R/G/B outputs of the VGA driver and decodes them back into pixel coordinates and pixel data. It locks onto the sync pattern, reconstructs row/col for every active pixel, counts frames and flags line/frame timing violations. It is used as an on-chip loopback checker and as the scoreboard front end in driver simulations.

---
 rtl/vga_capture_if.sv | 27 ++
 rtl/vga_capture.sv | 192 +++++++++++++++++++
 tb/tb_vga_capture.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_capture_if.sv
// VGA sink bundle: sync/colour from the driver side, decoded pixel stream and status back.
interface vga_capture_if;
  logic        HS;
  logic        VS;
  logic [3:0]  R;
  logic [3:0]  G;
  logic [3:0]  B;
  logic [8:0]  row;
  logic [9:0]  col;
  logic [11:0] pix;
  logic        pix_valid;
  logic        locked;
  logic [15:0] frame_cnt;
  logic        line_err;
  logic        frame_err;
  logic [15:0] checksum;

  modport master (
    output HS, VS, R, G, B,
    input  row, col, pix, pix_valid, locked, frame_cnt, line_err, frame_err, checksum
  );

  modport slave (
    input  HS, VS, R, G, B,
    output row, col, pix, pix_valid, locked, frame_cnt, line_err, frame_err, checksum
  );
endinterface

// File: rtl/vga_capture.sv
// Passive VGA sink: locks onto HS/VS, rebuilds row/col/pix, counts frames, flags timing errors.
// Optional per-frame pixel checksum is built when VGA_CAPTURE_CSUM_EN is defined.
module vga_capture #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic         clk,
  input  logic         rst,
  vga_capture_if.slave vga
);

  localparam logic [9:0] H_START_C = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END_C   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_START_C = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END_C   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [9:0] CNT_PRE   = 10'd1022;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  logic        s1_hs, s1_vs, s2_hs, s2_vs;
  logic [11:0] s1_rgb, s2_rgb;
  logic        hs_fall, vs_fall;
  logic [9:0]  hcnt, vcnt;
  logic        vs_pend;
  logic        line_viol, frame_viol, active;
  state_t      state;
  logic        line_bad;
  logic        lerr_q, ferr_q, fdone_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      s1_rgb <= '0;
      s2_rgb <= '0;
    end else begin
      s1_hs  <= vga.HS;
      s1_vs  <= vga.VS;
      s1_rgb <= {vga.R, vga.G, vga.B};
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_rgb <= s1_rgb;
    end
  end

  assign hs_fall = s2_hs & ~s1_hs;
  assign vs_fall = s2_vs & ~s1_vs;

  // hcnt/vcnt describe the sample currently held in s2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt    <= '0;
      vcnt    <= '0;
      vs_pend <= 1'b0;
    end else begin
      if (hs_fall)
        hcnt <= '0;
      else if (hcnt != CNT_MAX)
        hcnt <= hcnt + 10'd1;

      if (hs_fall) begin
        if (vs_pend || vs_fall)
          vcnt <= '0;
        else if (vcnt != CNT_MAX)
          vcnt <= vcnt + 10'd1;
        vs_pend <= 1'b0;
      end else if (vs_fall) begin
        vs_pend <= 1'b1;
      end
    end
  end

  assign line_viol  = (hs_fall && hcnt != H_LAST_C) || (!hs_fall && hcnt == CNT_PRE);
  assign frame_viol = vs_fall && vcnt != V_LAST_C;
  assign active     = (hcnt >= H_START_C) && (hcnt < H_END_C) &&
                      (vcnt >= V_START_C) && (vcnt < V_END_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      line_bad <= 1'b0;
      lerr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      lerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      fdone_q <= 1'b0;
      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state    <= ALIGN;
            line_bad <= 1'b0;
          end
        end
        ALIGN: begin
          if (line_viol)
            lerr_q <= 1'b1;
          if (vs_fall) begin
            if (frame_viol || line_bad || line_viol)
              ferr_q <= 1'b1;
            else
              state <= LOCKED;
            line_bad <= 1'b0;
          end else if (line_viol) begin
            line_bad <= 1'b1;
          end
        end
        LOCKED: begin
          if (line_viol)
            lerr_q <= 1'b1;
          if (frame_viol)
            ferr_q <= 1'b1;
          if (line_viol || frame_viol) begin
            state    <= ALIGN;
            // Dropping out mid-frame leaves a partial frame that must not count as an attempt.
            line_bad <= line_viol && !vs_fall;
          end else if (vs_fall) begin
            fdone_q <= 1'b1;
          end
        end
        default: begin
          state    <= SEARCH;
          line_bad <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga.row       <= '0;
      vga.col       <= '0;
      vga.pix       <= '0;
      vga.pix_valid <= 1'b0;
      vga.locked    <= 1'b0;
      vga.frame_cnt <= '0;
      vga.line_err  <= 1'b0;
      vga.frame_err <= 1'b0;
    end else begin
      vga.line_err  <= lerr_q;
      vga.frame_err <= ferr_q;
      vga.locked    <= (state == LOCKED);
      if (fdone_q)
        vga.frame_cnt <= vga.frame_cnt + 16'd1;
      vga.pix_valid <= active && (state == LOCKED);
      if (active && (state == LOCKED)) begin
        vga.row <= 9'(vcnt - V_START_C);
        vga.col <= hcnt - H_START_C;
        vga.pix <= s2_rgb;
      end
    end
  end

`ifdef VGA_CAPTURE_CSUM_EN
  logic        vsf_q;
  logic [15:0] acc;
  logic [15:0] addend;

  assign addend = vga.pix_valid ? {4'b0000, vga.pix} : 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsf_q        <= 1'b0;
      acc          <= '0;
      vga.checksum <= '0;
    end else begin
      vsf_q <= vs_fall;
      if (vsf_q) begin
        vga.checksum <= acc + addend;
        acc          <= '0;
      end else begin
        acc <= acc + addend;
      end
    end
  end
`else
  assign vga.checksum = 16'd0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: frame table drives a reduced-timing VGA source, pixels checked via a queue.
module tb_vga_capture;
  localparam int H_SYNC = 4, H_BP = 4, H_ACTIVE = 16, H_TOTAL = 32;
  localparam int V_SYNC = 2, V_BP = 2, V_ACTIVE = 6, V_TOTAL = 12;
  localparam int H_START = H_SYNC + H_BP, V_START = V_SYNC + V_BP;
`ifdef VGA_CAPTURE_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_capture_if vga();

  vga_capture #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga)
  );

  typedef struct {
    int nlines;
    int short_line;
    int rst_line;
    int mode;
    int exp_locked;
    int exp_lerr;
    int exp_ferr;
    int exp_fcnt;
  } frame_rec_t;

  typedef struct {
    logic [8:0]  row;
    logic [9:0]  col;
    logic [11:0] pix;
    int          cyc;
  } px_t;

  frame_rec_t tbl[13];
  px_t        sbq[$];
  int         cyc, n_checks, n_fail;
  int         lerr_cnt, ferr_cnt, lerr_base, ferr_base;
  int         locked_rise_cyc, ferr_cyc, vs_cyc;
  logic       prev_locked;
  logic [15:0] frame_sum, prev_sum;
  logic [8:0] last_row;
  logic [9:0] last_col;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_a"}, 64'({vga.row, vga.col, vga.pix, vga.pix_valid, vga.locked}), 64'd0);
    check({name, "_b"}, 64'({vga.frame_cnt, vga.line_err, vga.frame_err, vga.checksum}), 64'd0);
  endtask

  task automatic monitor();
    px_t e;
    if (vga.line_err) lerr_cnt++;
    if (vga.frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (vga.locked && !prev_locked) locked_rise_cyc = cyc;
    prev_locked = vga.locked;
    if (vga.pix_valid) begin
      if (sbq.size() == 0) begin
        check("pix_unexpected_valid", 64'(vga.pix_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        check("pix_row", 64'(vga.row), 64'(e.row));
        check("pix_col", 64'(vga.col), 64'(e.col));
        check("pix_data", 64'(vga.pix), 64'(e.pix));
        check("pix_latency", 64'(cyc), 64'(e.cyc));
        last_row = vga.row;
        last_col = vga.col;
      end
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic [11:0] rgb, input bit push,
                      input logic [8:0] row, input logic [9:0] col, input bit rst_on, input bit rst_off);
    px_t e;
    @(posedge clk);
    cyc++;
    #1;
    vga.HS = hs;
    vga.VS = vs;
    {vga.R, vga.G, vga.B} = rgb;
    if (rst_off) rst = 1'b0;
    if (push) begin
      e.row = row;
      e.col = col;
      e.pix = rgb;
      e.cyc = cyc + 3;
      sbq.push_back(e);
      frame_sum = frame_sum + {4'b0000, rgb};
    end
    if (rst_on) begin
      check("sb_drained_before_reset", 64'(sbq.size()), 64'd0);
      rst = 1'b1;
      #2;
      check_zero("reset_async");
      sbq.delete();
      frame_sum = '0;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic check_frame(input int idx);
    frame_rec_t r;
    r = tbl[idx];
    check("locked", 64'(vga.locked), 64'(r.exp_locked));
    check("frame_cnt", 64'(vga.frame_cnt), 64'(r.exp_fcnt));
    check("line_err_pulses", 64'(lerr_cnt - lerr_base), 64'(r.exp_lerr));
    check("frame_err_pulses", 64'(ferr_cnt - ferr_base), 64'(r.exp_ferr));
    check("checksum", 64'(vga.checksum), CSUM_EN ? 64'(prev_sum) : 64'd0);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    lerr_base = lerr_cnt;
    ferr_base = ferr_cnt;
    if (idx == 1) check("lock_latency", 64'(locked_rise_cyc), 64'(vs_cyc + 3));
    if (idx == 2) check("last_pixel", 64'({last_row, last_col}), 64'({9'(V_ACTIVE - 1), 10'(H_ACTIVE - 1)}));
    if (idx == 7) check("frame_err_latency", 64'(ferr_cyc), 64'(vs_cyc + 3));
  endtask

  task automatic run_frame(input int idx);
    frame_rec_t r;
    int len, stop;
    logic [9:0] cv, rv;
    logic [11:0] pixel;
    bit act;
    r = tbl[idx];
    stop = (r.short_line >= 0) ? r.short_line + 1 : ((r.rst_line >= 0) ? r.rst_line : r.nlines);
    for (int v = 0; v < r.nlines; v++) begin
      len = (v == r.short_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int h = 0; h < len; h++) begin
        act = (h >= H_START) && (h < H_START + H_ACTIVE) && (v >= V_START) && (v < V_START + V_ACTIVE);
        cv = 10'(h - H_START);
        rv = 10'(v - V_START);
        pixel = !act ? 12'h000 : ((r.mode == 0) ? 12'h124 : {cv[3:0], rv[3:0], 4'h5});
        if (h == 0 && v == 0) begin
          vs_cyc = cyc + 1;
          prev_sum = frame_sum;
          frame_sum = '0;
        end
        step(h >= H_SYNC, v >= V_SYNC, pixel, (r.exp_locked != 0) && act && (v < stop),
             rv[8:0], cv, (v == r.rst_line) && (h == 2), (v == r.rst_line) && (h == 4));
        if (h == 6 && v == 0) check_frame(idx);
      end
    end
  endtask

  initial begin
    //         lines short rst mode lock lerr ferr fcnt
    tbl[0]  = '{12, -1, -1, 0, 0, 0, 0, 0};
    tbl[1]  = '{12, -1, -1, 0, 1, 0, 0, 0};
    tbl[2]  = '{12, -1, -1, 1, 1, 0, 0, 1};
    tbl[3]  = '{12,  5, -1, 0, 1, 0, 0, 2};
    tbl[4]  = '{12, -1, -1, 0, 0, 1, 1, 2};
    tbl[5]  = '{12, -1, -1, 1, 1, 0, 0, 2};
    tbl[6]  = '{11, -1, -1, 0, 1, 0, 0, 3};
    tbl[7]  = '{12, -1, -1, 0, 0, 0, 1, 3};
    tbl[8]  = '{12, -1, -1, 1, 1, 0, 0, 3};
    tbl[9]  = '{12, -1,  6, 0, 1, 0, 0, 4};
    tbl[10] = '{12, -1, -1, 0, 0, 0, 0, 0};
    tbl[11] = '{12, -1, -1, 1, 1, 0, 0, 0};
    tbl[12] = '{12, -1, -1, 0, 1, 0, 0, 1};

    cyc = 0; n_checks = 0; n_fail = 0;
    lerr_cnt = 0; ferr_cnt = 0; lerr_base = 0; ferr_base = 0;
    locked_rise_cyc = -1; ferr_cyc = -1; vs_cyc = 0;
    prev_locked = 1'b0;
    frame_sum = '0; prev_sum = '0;
    last_row = '0; last_col = '0;

    rst = 1'b1;
    vga.HS = 1'b1;
    vga.VS = 1'b1;
    {vga.R, vga.G, vga.B} = 12'h000;
    #10;
    check_zero("reset_state");
    #10;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 12'h000, 1'b0, 9'd0, 10'd0, 1'b0, 1'b0);
    check_zero("idle_after_reset");

    for (int i = 0; i < 13; i++) run_frame(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
